alu_result_packer: RTL and testbench
====================================

ALU_RESULT_PACKER -- requirements
Module: alu_result_packer

Interface
REQ-001 SHALL have parameter RES_WIDTH, default 32, which is the result width; it is a multiple of 8 in the range 8..32, and NUM_BYTES = RES_WIDTH/8.
REQ-002 SHALL have port CLK  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port Arith_OUT  in  RES_WIDTH  registered result from the arithmetic stage.
REQ-005 SHALL have port Carry_OUT  in  1  carry bit accompanying Arith_OUT.
REQ-006 SHALL have port Arith_Flag  in  1  result valid; every cycle it is high is one new result.
REQ-007 SHALL have port TX_DATA  out  8  byte to the serial transmitter, registered.
REQ-008 SHALL have port TX_VALID  out  1  TX_DATA is valid, registered.
REQ-009 SHALL have port TX_READY  in  1  the transmitter accepts a byte in any cycle where TX_VALID and TX_READY are both high.
REQ-010 SHALL have port BUSY  out  1  high when state is not IDLE or the pending buffer is full.
REQ-011 SHALL have port OVERRUN  out  1  sticky flag, set when a result has been dropped.
REQ-012 SHALL have port DROP_CNT  out  8  count of dropped results, saturating at 255.
REQ-013 SHALL have port OVR_CLR  in  1  synchronous clear of OVERRUN and DROP_CNT.

Function
REQ-014 SHALL transmit one frame per result: the header byte, then NUM_BYTES result bytes, least significant byte first.
REQ-015 SHALL build the header as {4'b1010, 1'b0, drop_pend, zero, carry}:
- zero = (captured result == 0).
- carry = captured Carry_OUT.
- drop_pend = internal drop-pending bit sampled when the result is loaded into the active register.
REQ-016 SHALL clear drop_pend when a result is loaded into the active register.
REQ-017 SHALL implement FSM states IDLE, HDR and DATA, with a byte index 0..NUM_BYTES-1.
REQ-018 SHALL, in IDLE with Arith_Flag=1 at cycle n, load the active register and present TX_VALID=1 with the header at cycle n+1 (state HDR).
REQ-019 SHALL hold TX_DATA and TX_VALID stable while TX_VALID=1 and TX_READY=0.
REQ-020 SHALL go from HDR to DATA with index 0 when the header is accepted.
REQ-021 SHALL increment the index in DATA on each accepted byte, with no idle cycle between bytes.
REQ-022 SHALL, when the last data byte is accepted:
- if the pending buffer is full, move it to the active register and go to HDR in the next cycle (no bubble);
- else if Arith_Flag=1 in the same cycle, load that result directly into the active register and go to HDR;
- else go to IDLE with TX_VALID=0.
REQ-023 SHALL, on Arith_Flag=1 while not IDLE and not at a load cycle, store the result in the single-entry pending buffer if it is empty.
REQ-024 SHALL, if the pending buffer is full in that case, drop the new result, set OVERRUN, set drop_pend and increment DROP_CNT (saturating at 255).
REQ-025 SHALL, on Arith_Flag=1 in a cycle where pending is moved to active, store the new result in pending with no drop.
REQ-026 SHALL make OVR_CLR clear OVERRUN and DROP_CNT; if a drop occurs in the same cycle, the result is OVERRUN=1 and DROP_CNT=1.
REQ-027 SHALL never alter the active frame contents while a frame is in transmission.

Reset
REQ-028 SHALL, while RST=0, force state IDLE, TX_DATA=0x00, TX_VALID=0, BUSY=0, OVERRUN=0, DROP_CNT=0, drop_pend=0 and pending empty, asynchronously.
REQ-029 SHALL, on reset asserted mid-frame, abandon the frame; no remaining bytes are sent after release.
REQ-030 SHALL accept Arith_Flag in the first clock edge after RST deasserts.

Verification
REQ-031 SHALL cover single frame: Arith_OUT=0x12345678, Carry_OUT=1, one-cycle Arith_Flag, TX_READY=1 -> header at n+1, then bytes 0xA1, 0x78, 0x56, 0x34, 0x12 on consecutive cycles, then TX_VALID=0.
REQ-032 SHALL cover zero result: Arith_OUT=0, Carry_OUT=0 -> header 0xA2, then four 0x00 bytes.
REQ-033 SHALL cover backpressure: TX_READY=0 for 3 cycles during byte 0x56 -> TX_DATA holds 0x56 and TX_VALID stays 1, with no byte lost or duplicated.
REQ-034 SHALL cover overrun: TX_READY=0 and three Arith_Flag pulses (R1, R2, R3) -> R1 is sent, R2 is pending, R3 is dropped; OVERRUN=1, DROP_CNT=1, and R2's header has bit2=1 (0xA4 | zero | carry).
REQ-035 SHALL cover back-to-back frames: new Arith_Flag on the cycle the last byte of R1 is accepted -> the R2 header appears on the next cycle with no idle gap.
REQ-036 SHALL cover reset mid-frame: RST=0 after the header is accepted -> outputs at reset values immediately; after release, TX_VALID stays 0 until the next Arith_Flag.

Source files
------------

// File: rtl/alu_result_packer.sv
// Serialises each ALU result into a header byte plus LSB-first data bytes,
// with a one-entry pending buffer and overrun accounting for dropped results.
module alu_result_packer #(
   parameter int RES_WIDTH = 32
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [RES_WIDTH-1:0] Arith_OUT,
   input  logic                 Carry_OUT,
   input  logic                 Arith_Flag,
   output logic [7:0]           TX_DATA,
   output logic                 TX_VALID,
   input  logic                 TX_READY,
   output logic                 BUSY,
   output logic                 OVERRUN,
   output logic [7:0]           DROP_CNT,
   input  logic                 OVR_CLR
);

   localparam int NUM_BYTES = RES_WIDTH / 8;
   localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

   typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

   state_t                 r_state,      w_state_nxt;
   logic [IDX_W-1:0]       r_idx,        w_idx_nxt;
   logic [RES_WIDTH-1:0]   r_act_data,   w_act_data_nxt;
   logic                   r_pend_valid, w_pend_valid_nxt;
   logic [RES_WIDTH-1:0]   r_pend_data,  w_pend_data_nxt;
   logic                   r_pend_carry, w_pend_carry_nxt;
   logic                   r_drop_pend,  w_drop_pend_nxt;
   logic [7:0]             r_tx_data,    w_tx_data_nxt;
   logic                   r_tx_valid,   w_tx_valid_nxt;
   logic                   r_overrun,    w_overrun_nxt;
   logic [7:0]             r_drop_cnt,   w_drop_cnt_nxt;

   logic                   w_accept;
   logic                   w_load;
   logic                   w_drop;
   logic [RES_WIDTH-1:0]   w_load_data;
   logic                   w_load_carry;
   logic [IDX_W-1:0]       w_idx_inc;
   logic [7:0]             w_bytes [NUM_BYTES];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BYTES; gi++) begin : g_bytes
         assign w_bytes[gi] = r_act_data[gi*8 +: 8];
      end
   endgenerate

   assign w_accept  = r_tx_valid & TX_READY;
   assign w_idx_inc = r_idx + 1'b1;

   always_comb begin
      w_state_nxt      = r_state;
      w_idx_nxt        = r_idx;
      w_act_data_nxt   = r_act_data;
      w_pend_valid_nxt = r_pend_valid;
      w_pend_data_nxt  = r_pend_data;
      w_pend_carry_nxt = r_pend_carry;
      w_drop_pend_nxt  = r_drop_pend;
      w_tx_data_nxt    = r_tx_data;
      w_tx_valid_nxt   = r_tx_valid;
      w_overrun_nxt    = r_overrun;
      w_drop_cnt_nxt   = r_drop_cnt;
      w_load           = 1'b0;
      w_drop           = 1'b0;
      w_load_data      = Arith_OUT;
      w_load_carry     = Carry_OUT;

      case (r_state)
         IDLE: begin
            if (Arith_Flag) w_load = 1'b1;
         end
         HDR: begin
            if (w_accept) begin
               w_state_nxt   = DATA;
               w_idx_nxt     = '0;
               w_tx_data_nxt = w_bytes[0];
            end
         end
         DATA: begin
            if (w_accept) begin
               if (r_idx == LAST_IDX) begin
                  // Frame done: pending result has priority over a fresh one.
                  if (r_pend_valid) begin
                     w_load           = 1'b1;
                     w_load_data      = r_pend_data;
                     w_load_carry     = r_pend_carry;
                     w_pend_valid_nxt = Arith_Flag;
                     w_pend_data_nxt  = Arith_OUT;
                     w_pend_carry_nxt = Carry_OUT;
                  end else if (Arith_Flag) begin
                     w_load = 1'b1;
                  end else begin
                     w_state_nxt    = IDLE;
                     w_tx_valid_nxt = 1'b0;
                  end
               end else begin
                  w_idx_nxt     = w_idx_inc;
                  w_tx_data_nxt = w_bytes[w_idx_inc];
               end
            end
         end
         default: begin
            w_state_nxt    = IDLE;
            w_tx_valid_nxt = 1'b0;
         end
      endcase

      if (Arith_Flag && (r_state != IDLE) && !w_load) begin
         if (!r_pend_valid) begin
            w_pend_valid_nxt = 1'b1;
            w_pend_data_nxt  = Arith_OUT;
            w_pend_carry_nxt = Carry_OUT;
         end else begin
            w_drop = 1'b1;
         end
      end

      if (w_load) begin
         w_state_nxt     = HDR;
         w_tx_valid_nxt  = 1'b1;
         w_act_data_nxt  = w_load_data;
         w_tx_data_nxt   = {4'b1010, 1'b0, r_drop_pend, (w_load_data == '0), w_load_carry};
         w_drop_pend_nxt = 1'b0;
      end
      if (w_drop) w_drop_pend_nxt = 1'b1;

      // A clear coinciding with a drop leaves exactly that one drop recorded.
      if (OVR_CLR) begin
         w_overrun_nxt  = w_drop;
         w_drop_cnt_nxt = {7'd0, w_drop};
      end else if (w_drop) begin
         w_overrun_nxt = 1'b1;
         if (r_drop_cnt != 8'hFF) w_drop_cnt_nxt = r_drop_cnt + 8'd1;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state      <= IDLE;
         r_idx        <= '0;
         r_act_data   <= '0;
         r_pend_valid <= 1'b0;
         r_pend_data  <= '0;
         r_pend_carry <= 1'b0;
         r_drop_pend  <= 1'b0;
         r_tx_data    <= 8'h00;
         r_tx_valid   <= 1'b0;
         r_overrun    <= 1'b0;
         r_drop_cnt   <= 8'h00;
      end else begin
         r_state      <= w_state_nxt;
         r_idx        <= w_idx_nxt;
         r_act_data   <= w_act_data_nxt;
         r_pend_valid <= w_pend_valid_nxt;
         r_pend_data  <= w_pend_data_nxt;
         r_pend_carry <= w_pend_carry_nxt;
         r_drop_pend  <= w_drop_pend_nxt;
         r_tx_data    <= w_tx_data_nxt;
         r_tx_valid   <= w_tx_valid_nxt;
         r_overrun    <= w_overrun_nxt;
         r_drop_cnt   <= w_drop_cnt_nxt;
      end
   end

   assign TX_DATA  = r_tx_data;
   assign TX_VALID = r_tx_valid;
   assign BUSY     = (r_state != IDLE) || r_pend_valid;
   assign OVERRUN  = r_overrun;
   assign DROP_CNT = r_drop_cnt;

endmodule

// File: tb/tb_alu_result_packer.sv
// Bench for alu_result_packer: directed scenarios plus random traffic, all
// checked against a frame-queue model of the byte stream and drop accounting.
module tb_alu_result_packer;

   localparam int RES_WIDTH = 32;
   localparam int NB        = RES_WIDTH / 8;

   logic                 CLK = 1'b0;
   logic                 RST = 1'b0;
   logic [RES_WIDTH-1:0] Arith_OUT = '0;
   logic                 Carry_OUT = 1'b0;
   logic                 Arith_Flag = 1'b0;
   logic [7:0]           TX_DATA;
   logic                 TX_VALID;
   logic                 TX_READY = 1'b0;
   logic                 BUSY;
   logic                 OVERRUN;
   logic [7:0]           DROP_CNT;
   logic                 OVR_CLR = 1'b0;

   int n_vec  = 0;
   int n_err  = 0;
   int frames = 0;

   // Reference model: queue of bytes still to be sent for the current frame.
   logic [7:0]           m_q [$];
   logic                 m_pv;
   logic [RES_WIDTH-1:0] m_pd;
   logic                 m_pc;
   logic                 m_dp;
   logic                 m_ovr;
   logic [7:0]           m_cnt;

   alu_result_packer #(.RES_WIDTH(RES_WIDTH)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .Arith_OUT  (Arith_OUT),
      .Carry_OUT  (Carry_OUT),
      .Arith_Flag (Arith_Flag),
      .TX_DATA    (TX_DATA),
      .TX_VALID   (TX_VALID),
      .TX_READY   (TX_READY),
      .BUSY       (BUSY),
      .OVERRUN    (OVERRUN),
      .DROP_CNT   (DROP_CNT),
      .OVR_CLR    (OVR_CLR)
   );

   always #5 CLK = ~CLK;

   task automatic model_reset();
      m_q.delete();
      m_pv  = 1'b0;
      m_pd  = '0;
      m_pc  = 1'b0;
      m_dp  = 1'b0;
      m_ovr = 1'b0;
      m_cnt = 8'h00;
   endtask

   task automatic push_frame(input logic [RES_WIDTH-1:0] d, input logic c);
      logic [7:0] h;
      h = 8'hA0 | (m_dp ? 8'h04 : 8'h00) | ((d == 0) ? 8'h02 : 8'h00) | (c ? 8'h01 : 8'h00);
      m_dp = 1'b0;
      m_q.push_back(h);
      for (int k = 0; k < NB; k++) m_q.push_back(d[8*k +: 8]);
   endtask

   function automatic logic [7:0] hdr_of(input logic [RES_WIDTH-1:0] d, input logic c,
                                         input logic dp);
      return 8'hA0 | (dp ? 8'h04 : 8'h00) | ((d == 0) ? 8'h02 : 8'h00) | (c ? 8'h01 : 8'h00);
   endfunction

   task automatic model_step();
      logic drop;
      drop = 1'b0;
      if (m_q.size() > 0 && TX_READY) begin
         void'(m_q.pop_front());
         if (m_q.size() == 0) begin
            frames++;
            $display("frame %0d complete at %0t", frames, $time);
         end
      end
      if (m_q.size() == 0) begin
         if (m_pv) begin
            push_frame(m_pd, m_pc);
            m_pv = Arith_Flag;
            m_pd = Arith_OUT;
            m_pc = Carry_OUT;
         end else if (Arith_Flag) begin
            push_frame(Arith_OUT, Carry_OUT);
         end
      end else if (Arith_Flag) begin
         if (!m_pv) begin
            m_pv = 1'b1;
            m_pd = Arith_OUT;
            m_pc = Carry_OUT;
         end else begin
            drop = 1'b1;
            $display("result %h dropped at %0t", Arith_OUT, $time);
         end
      end
      if (drop) m_dp = 1'b1;
      if (OVR_CLR) begin
         m_ovr = drop;
         m_cnt = drop ? 8'd1 : 8'd0;
      end else if (drop) begin
         m_ovr = 1'b1;
         if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
      end
   endtask

   function automatic logic [18:0] model_vec();
      logic v;
      v = (m_q.size() > 0);
      return {v, (v ? m_q[0] : 8'h00), (v || m_pv), m_ovr, m_cnt};
   endfunction

   function automatic logic [18:0] dut_vec();
      return {TX_VALID, (TX_VALID ? TX_DATA : 8'h00), BUSY, OVERRUN, DROP_CNT};
   endfunction

   // Drives inputs at the falling edge, clocks once, returns at the next falling edge.
   task automatic cycle(input logic f, input logic [RES_WIDTH-1:0] d, input logic c,
                        input logic rdy, input logic clr);
      Arith_Flag = f;
      Arith_OUT  = d;
      Carry_OUT  = c;
      TX_READY   = rdy;
      OVR_CLR    = clr;
      @(posedge CLK);
      model_step();
      @(negedge CLK);
   endtask

   task automatic apply_reset();
      @(negedge CLK);
      RST = 1'b0;
      Arith_Flag = 1'b0;
      TX_READY = 1'b0;
      OVR_CLR = 1'b0;
      model_reset();
      repeat (2) @(negedge CLK);
      RST = 1'b1;
   endtask

   task automatic test_reset();
      RST = 1'b0;
      Arith_Flag = 1'b1;
      TX_READY = 1'b1;
      Arith_OUT = 32'h12345678;
      model_reset();
      #1;
      n_vec++;
      if (dut_vec() !== 19'h0 || TX_DATA !== 8'h00) begin
         n_err++;
         $display("FAIL reset_state: got %h data %h, expected 0 data 00", dut_vec(), TX_DATA);
      end
      @(posedge CLK);
      #1;
      n_vec++;
      if (dut_vec() !== 19'h0) begin
         n_err++;
         $display("FAIL reset_hold: got %h, expected 0", dut_vec());
      end
   endtask

   task automatic run_frame(input string name, input logic [RES_WIDTH-1:0] d, input logic c,
                            input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                            input logic [7:0] e3, input logic [7:0] e4);
      logic [7:0] exp_b [5];
      exp_b = '{e0, e1, e2, e3, e4};
      apply_reset();
      cycle(1'b1, d, c, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         n_vec++;
         if ({TX_VALID, TX_DATA} !== {1'b1, exp_b[i]} || dut_vec() !== model_vec()) begin
            n_err++;
            $display("FAIL %s byte %0d: got valid %b data %h, expected valid 1 data %h",
                     name, i, TX_VALID, TX_DATA, exp_b[i]);
         end
         cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
      end
      n_vec++;
      if (TX_VALID !== 1'b0 || BUSY !== 1'b0) begin
         n_err++;
         $display("FAIL %s end: got valid %b busy %b, expected 0 0", name, TX_VALID, BUSY);
      end
   endtask

   task automatic test_single_frame();
      run_frame("single_frame", 32'h12345678, 1'b1, 8'hA1, 8'h78, 8'h56, 8'h34, 8'h12);
   endtask

   task automatic test_zero_result();
      run_frame("zero_result", 32'h0, 1'b0, 8'hA2, 8'h00, 8'h00, 8'h00, 8'h00);
   endtask

   task automatic test_backpressure();
      logic [7:0] acc [$];
      logic [7:0] exp_b [5];
      logic       rdy;
      exp_b = '{8'hA1, 8'h78, 8'h56, 8'h34, 8'h12};
      apply_reset();
      cycle(1'b1, 32'h12345678, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 12; i++) begin
         rdy = !(i >= 2 && i < 5);
         if (TX_VALID && rdy) acc.push_back(TX_DATA);
         cycle(1'b0, '0, 1'b0, rdy, 1'b0);
         n_vec++;
         if (dut_vec() !== model_vec()) begin
            n_err++;
            $display("FAIL backpressure_model cyc %0d: got %h expected %h", i, dut_vec(), model_vec());
         end
         if (i >= 1 && i <= 4) begin
            n_vec++;
            if ({TX_VALID, TX_DATA} !== {1'b1, 8'h56}) begin
               n_err++;
               $display("FAIL backpressure_hold cyc %0d: got valid %b data %h, expected valid 1 data 56",
                        i, TX_VALID, TX_DATA);
            end
         end
      end
      n_vec++;
      if (acc.size() != 5) begin
         n_err++;
         $display("FAIL backpressure_count: got %0d bytes accepted, expected 5", acc.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (acc[i] !== exp_b[i]) begin
               n_err++;
               $display("FAIL backpressure_seq %0d: got %h expected %h", i, acc[i], exp_b[i]);
            end
         end
      end
   endtask

   task automatic test_overrun();
      logic [RES_WIDTH-1:0] r [4];
      logic                 c [4];
      logic [7:0]           exp_h;
      int                   accepted;
      logic                 seen;
      for (int k = 0; k < 4; k++) begin
         r[k] = $urandom();
         c[k] = 1'($urandom_range(0, 1));
      end
      r[1] = ($urandom_range(0, 1) == 0) ? '0 : r[1];
      apply_reset();
      for (int k = 0; k < 4; k++) begin
         cycle(1'b1, r[k], c[k], 1'b0, (k == 3));
         n_vec++;
         if (dut_vec() !== model_vec()) begin
            n_err++;
            $display("FAIL overrun_model pulse %0d: got %h expected %h", k, dut_vec(), model_vec());
         end
         if (k >= 2) begin
            n_vec++;
            if ({OVERRUN, DROP_CNT} !== {1'b1, 8'd1}) begin
               n_err++;
               $display("FAIL overrun_flag pulse %0d: got ovr %b cnt %0d, expected ovr 1 cnt 1",
                        k, OVERRUN, DROP_CNT);
            end
         end
      end
      exp_h = hdr_of(r[1], c[1], 1'b1);
      accepted = 0;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (TX_VALID) accepted++;
         cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
         n_vec++;
         if (dut_vec() !== model_vec()) begin
            n_err++;
            $display("FAIL overrun_model drain %0d: got %h expected %h", i, dut_vec(), model_vec());
         end
         if (accepted == NB + 1 && !seen) begin
            seen = 1'b1;
            n_vec++;
            if ({TX_VALID, TX_DATA} !== {1'b1, exp_h}) begin
               n_err++;
               $display("FAIL overrun_r2_header: got valid %b data %h, expected valid 1 data %h",
                        TX_VALID, TX_DATA, exp_h);
            end
         end
      end
      n_vec++;
      if (!seen || TX_VALID !== 1'b0) begin
         n_err++;
         $display("FAIL overrun_drain: got seen %b valid %b, expected seen 1 valid 0", seen, TX_VALID);
      end
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
      n_vec++;
      if ({OVERRUN, DROP_CNT} !== {1'b0, 8'd0}) begin
         n_err++;
         $display("FAIL overrun_clear: got ovr %b cnt %0d, expected ovr 0 cnt 0", OVERRUN, DROP_CNT);
      end
   endtask

   task automatic test_back_to_back();
      logic [RES_WIDTH-1:0] r1, r2;
      logic                 c1, c2;
      r1 = $urandom();
      r2 = $urandom();
      c1 = 1'($urandom_range(0, 1));
      c2 = 1'($urandom_range(0, 1));
      apply_reset();
      cycle(1'b1, r1, c1, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
         n_vec++;
         if (dut_vec() !== model_vec()) begin
            n_err++;
            $display("FAIL b2b_model cyc %0d: got %h expected %h", i, dut_vec(), model_vec());
         end
      end
      cycle(1'b1, r2, c2, 1'b1, 1'b0);
      n_vec++;
      if ({TX_VALID, TX_DATA} !== {1'b1, hdr_of(r2, c2, 1'b0)}) begin
         n_err++;
         $display("FAIL b2b_header: got valid %b data %h, expected valid 1 data %h",
                  TX_VALID, TX_DATA, hdr_of(r2, c2, 1'b0));
      end
      for (int i = 0; i < NB + 2; i++) begin
         cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
         n_vec++;
         if (dut_vec() !== model_vec()) begin
            n_err++;
            $display("FAIL b2b_tail cyc %0d: got %h expected %h", i, dut_vec(), model_vec());
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      apply_reset();
      cycle(1'b1, 32'hCAFE0001, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
      #2;
      RST = 1'b0;
      model_reset();
      #1;
      n_vec++;
      if (dut_vec() !== 19'h0 || TX_DATA !== 8'h00) begin
         n_err++;
         $display("FAIL reset_mid_async: got %h data %h, expected 0 data 00", dut_vec(), TX_DATA);
      end
      @(negedge CLK);
      RST = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
         n_vec++;
         if (TX_VALID !== 1'b0 || dut_vec() !== model_vec()) begin
            n_err++;
            $display("FAIL reset_mid_idle cyc %0d: got %h expected %h", i, dut_vec(), model_vec());
         end
      end
   endtask

   task automatic test_saturation();
      apply_reset();
      for (int i = 0; i < 260; i++) begin
         cycle(1'b1, $urandom(), 1'b0, 1'b0, 1'b0);
         n_vec++;
         if (dut_vec() !== model_vec()) begin
            n_err++;
            $display("FAIL saturation_model cyc %0d: got %h expected %h", i, dut_vec(), model_vec());
         end
      end
      n_vec++;
      if (DROP_CNT !== 8'd255 || OVERRUN !== 1'b1) begin
         n_err++;
         $display("FAIL saturation_cnt: got cnt %0d ovr %b, expected cnt 255 ovr 1", DROP_CNT, OVERRUN);
      end
   endtask

   task automatic test_random();
      logic [RES_WIDTH-1:0] d;
      apply_reset();
      for (int i = 0; i < 3000; i++) begin
         d = ($urandom_range(0, 7) == 0) ? '0 : $urandom();
         cycle($urandom_range(0, 99) < 30, d, 1'($urandom_range(0, 1)),
               $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 3);
         n_vec++;
         if (dut_vec() !== model_vec()) begin
            n_err++;
            $display("FAIL random_model cyc %0d: got %h expected %h", i, dut_vec(), model_vec());
         end
      end
      for (int i = 0; i < 3 * (NB + 1); i++) begin
         cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
         n_vec++;
         if (dut_vec() !== model_vec()) begin
            n_err++;
            $display("FAIL random_drain cyc %0d: got %h expected %h", i, dut_vec(), model_vec());
         end
      end
      n_vec++;
      if (TX_VALID !== 1'b0 || BUSY !== 1'b0) begin
         n_err++;
         $display("FAIL random_idle: got valid %b busy %b, expected 0 0", TX_VALID, BUSY);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_frame();
      test_zero_result();
      test_backpressure();
      test_overrun();
      test_back_to_back();
      test_reset_mid_frame();
      test_saturation();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
